mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes exe_to_mem_t and performs loads/stores to data memory over a req/gnt/rvalid bus.
- Aligns and extends load data, generates store byte-enables, and registers a mem_to_wb_t toward writeback.
- Raises stall_o toward the upstream stages while a memory transaction is outstanding.

---
 rtl/tartaruga_pkg.sv | 52 +++++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_stage_align.sv | 53 +++++
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tartaruga_pkg.sv
// Shared pipeline types for the tartaruga core: instruction fields,
// execute->mem and mem->writeback bundles, and the mem-stage FSM states.
package tartaruga_pkg;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE
  } mem_op_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } mem_size_t;

  typedef struct packed {
    logic [31:0] raw;
    mem_op_t     mem_op;
    mem_size_t   mem_size;
    logic        mem_unsigned;
  } instr_t;

  localparam instr_t INSTR_NOP = '{
    raw:          32'h0000_0013,
    mem_op:       MEM_NONE,
    mem_size:     WORD,
    mem_unsigned: 1'b0
  };

  typedef struct packed {
    logic        valid;
    instr_t      instr;
    logic [31:0] result;
    logic [31:0] data_rs2;
    logic        branch_taken;
  } exe_to_mem_t;

  typedef struct packed {
    logic        valid;
    instr_t      instr;
    logic [31:0] result;
    logic        exc_misaligned;
  } mem_to_wb_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: req/gnt request phase, rvalid response phase.
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store byte enables / replicated data, load
// alignment and extension. Misaligned offsets are folded down.
module mem_align
  import tartaruga_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misal
);
  logic [1:0]  eff;
  logic [31:0] sh;

  always_comb begin
    eff   = off;
    be    = 4'b0000;
    wdata = rs2;
    misal = 1'b0;
    unique case (1'b1)
      size == BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{rs2[7:0]}};
      end
      size == HALF: begin
        eff   = {off[1], 1'b0};
        be    = 4'b0011 << eff;
        wdata = {2{rs2[15:0]}};
        misal = off[0];
      end
      default: begin
        eff   = 2'b00;
        be    = 4'b1111;
        misal = |off;
      end
    endcase

    sh    = rdata >> {eff, 3'b000};
    ldata = sh;
    unique case (1'b1)
      size == BYTE:
        ldata = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      size == HALF:
        ldata = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      default:
        ldata = sh;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage. Define MEM_MISALIGN_EXC_EN to trap misaligned
// accesses instead of silently aligning them.
module mem_stage
  import tartaruga_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  exe_to_mem_t exe_to_mem_i,
  output mem_to_wb_t  mem_to_wb_o,
  output logic        stall_o,
  mem_stage_if.master dmem
);
  mem_state_t  state_q, state_d;
  instr_t      lat_instr_q;
  logic [31:0] lat_addr_q, lat_rs2_q;

  instr_t      cur_instr;
  logic [31:0] cur_addr, cur_rs2;
  logic        is_idle, in_mem, misal, exc;
  logic        req, done;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;

  assign is_idle = (state_q == IDLE);
  assign in_mem  = exe_to_mem_i.valid &&
                   exe_to_mem_i.instr.mem_op != MEM_NONE;

  // Once a request is out, the bus sees only the latched copy.
  assign cur_instr = is_idle ? exe_to_mem_i.instr    : lat_instr_q;
  assign cur_addr  = is_idle ? exe_to_mem_i.result   : lat_addr_q;
  assign cur_rs2   = is_idle ? exe_to_mem_i.data_rs2 : lat_rs2_q;

  mem_align u_align (
    .size        (cur_instr.mem_size),
    .off         (cur_addr[1:0]),
    .is_unsigned (cur_instr.mem_unsigned),
    .rs2         (cur_rs2),
    .rdata       (dmem.rdata[31:0]),
    .be          (be),
    .wdata       (wdata),
    .ldata       (ldata),
    .misal       (misal)
  );

`ifdef MEM_MISALIGN_EXC_EN
  assign exc = is_idle && in_mem && misal;
`else
  assign exc = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{exe_to_mem_i.branch_taken, misal};

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall_o = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_mem && !exc) begin
          req = 1'b1;
          if (dmem.gnt && dmem.rvalid) begin
            done = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = dmem.gnt ? WAIT_RSP : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem.gnt && dmem.rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (dmem.gnt) state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem.rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.req   = req;
  assign dmem.we    = req && cur_instr.mem_op == MEM_STORE;
  assign dmem.addr  = req ? ADDR_W'({cur_addr[31:2], 2'b00}) : '0;
  assign dmem.be    = req ? be : 4'b0000;
  assign dmem.wdata = req ? DATA_W'(wdata) : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      lat_instr_q <= INSTR_NOP;
      lat_addr_q  <= '0;
      lat_rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      if (is_idle && req) begin
        lat_instr_q <= exe_to_mem_i.instr;
        lat_addr_q  <= exe_to_mem_i.result;
        lat_rs2_q   <= exe_to_mem_i.data_rs2;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_to_wb_o <= '{valid: 1'b0, instr: INSTR_NOP,
                       result: '0, exc_misaligned: 1'b0};
    end else if (done) begin
      mem_to_wb_o.valid          <= 1'b1;
      mem_to_wb_o.instr          <= cur_instr;
      mem_to_wb_o.result         <=
        (cur_instr.mem_op == MEM_STORE) ? 32'h0 : ldata;
      mem_to_wb_o.exc_misaligned <= 1'b0;
    end else if (exc) begin
      mem_to_wb_o.valid          <= 1'b1;
      mem_to_wb_o.instr          <= exe_to_mem_i.instr;
      mem_to_wb_o.result         <= exe_to_mem_i.result;
      mem_to_wb_o.exc_misaligned <= 1'b1;
    end else if (is_idle && !in_mem) begin
      mem_to_wb_o.valid          <= exe_to_mem_i.valid;
      mem_to_wb_o.instr          <= exe_to_mem_i.instr;
      mem_to_wb_o.result         <= exe_to_mem_i.result;
      mem_to_wb_o.exc_misaligned <= 1'b0;
    end else begin
      mem_to_wb_o <= '{valid: 1'b0, instr: INSTR_NOP,
                       result: '0, exc_misaligned: 1'b0};
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, stores, loads,
// bus wait states, reset mid-transaction and misaligned word access.
module tb_mem_stage;
  import tartaruga_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  exe_to_mem_t exe;
  mem_to_wb_t  wb;
  logic        stall;

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_stage dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .exe_to_mem_i (exe),
    .mem_to_wb_o  (wb),
    .stall_o      (stall),
    .dmem         (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    exe         = '0;
    exe.instr   = INSTR_NOP;
    bus.gnt     = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
  endtask

  task automatic put(input mem_op_t op, input mem_size_t sz,
                     input logic uns, input logic [31:0] res,
                     input logic [31:0] rs2);
    exe                    = '0;
    exe.valid              = 1'b1;
    exe.instr              = INSTR_NOP;
    exe.instr.raw          = 32'h0000_0003;
    exe.instr.mem_op       = op;
    exe.instr.mem_size     = sz;
    exe.instr.mem_unsigned = uns;
    exe.result             = res;
    exe.data_rs2           = rs2;
  endtask

  logic       g_seq [6] = '{0, 0, 1, 0, 0, 0};
  logic       r_seq [6] = '{0, 0, 0, 0, 0, 1};
  logic       s_exp [6] = '{1, 1, 1, 1, 1, 0};
  logic       q_exp [6] = '{1, 1, 1, 0, 0, 0};
  int         stall_cnt;

  initial begin
    idle();
    #12;
    check("rst_wb_valid", 32'(wb.valid), 32'h0);
    check("rst_wb_instr", wb.instr.raw, INSTR_NOP.raw);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_be", 32'(bus.be), 32'h0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // ALU pass-through
    @(negedge clk);
    put(MEM_NONE, WORD, 1'b0, 32'h1234, 32'h0);
    #1;
    check("alu_req", 32'(bus.req), 32'h0);
    check("alu_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("alu_wb_valid", 32'(wb.valid), 32'h1);
    check("alu_wb_result", wb.result, 32'h1234);

    // Store byte, single-cycle completion
    @(negedge clk);
    put(MEM_STORE, BYTE, 1'b0, 32'h103, 32'h0000_00AB);
    bus.gnt = 1'b1; bus.rvalid = 1'b1;
    #1;
    check("sb_req", 32'(bus.req), 32'h1);
    check("sb_we", 32'(bus.we), 32'h1);
    check("sb_be", 32'(bus.be), 32'h8);
    check("sb_wdata", bus.wdata, 32'hABAB_ABAB);
    check("sb_addr", bus.addr, 32'h100);
    check("sb_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("sb_wb_valid", 32'(wb.valid), 32'h1);
    check("sb_wb_result", wb.result, 32'h0);

    // Store half at offset 2
    @(negedge clk);
    put(MEM_STORE, HALF, 1'b0, 32'h102, 32'h1234_BEEF);
    #1;
    check("sh_be", 32'(bus.be), 32'hC);
    check("sh_wdata", bus.wdata, 32'hBEEF_BEEF);

    // Load half signed / unsigned
    @(negedge clk);
    put(MEM_LOAD, HALF, 1'b0, 32'h202, 32'h0);
    bus.rdata = 32'h8001_0000;
    #1;
    check("lh_we", 32'(bus.we), 32'h0);
    check("lh_addr", bus.addr, 32'h200);
    check("lh_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("lh_result", wb.result, 32'hFFFF_8001);
    @(negedge clk);
    put(MEM_LOAD, HALF, 1'b1, 32'h202, 32'h0);
    @(posedge clk); #1;
    check("lhu_result", wb.result, 32'h0000_8001);

    // Load byte signed at offset 1
    @(negedge clk);
    put(MEM_LOAD, BYTE, 1'b0, 32'h101, 32'h0);
    bus.rdata = 32'h1122_8344;
    @(posedge clk); #1;
    check("lb_result", wb.result, 32'hFFFF_FF83);

    // Load word with bus wait states; input changes under stall
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) put(MEM_LOAD, WORD, 1'b0, 32'h300, 32'h0);
      else put(MEM_STORE, BYTE, 1'b0, 32'h999, 32'h77);
      bus.gnt    = g_seq[c];
      bus.rvalid = r_seq[c];
      bus.rdata  = (c == 5) ? 32'hCAFE_F00D : 32'h0;
      #1;
      check($sformatf("lw_stall_c%0d", c), 32'(stall), 32'(s_exp[c]));
      check($sformatf("lw_req_c%0d", c), 32'(bus.req), 32'(q_exp[c]));
      if (q_exp[c]) begin
        check($sformatf("lw_addr_c%0d", c), bus.addr, 32'h300);
        check($sformatf("lw_be_c%0d", c), 32'(bus.be), 32'hF);
      end
      if (c > 0) check($sformatf("lw_bubble_c%0d", c), 32'(wb.valid), 32'h0);
      if (stall) stall_cnt++;
    end
    check("lw_stall_cycles", 32'(stall_cnt), 32'd5);
    @(posedge clk); #1;
    check("lw_wb_valid", 32'(wb.valid), 32'h1);
    check("lw_result", wb.result, 32'hCAFE_F00D);

    // Reset while waiting for the response
    @(negedge clk);
    put(MEM_LOAD, WORD, 1'b0, 32'h400, 32'h0);
    bus.gnt = 1'b1; bus.rvalid = 1'b0;
    #1;
    check("rr_stall0", 32'(stall), 32'h1);
    @(negedge clk);
    idle();
    #1;
    check("rr_req_wait", 32'(bus.req), 32'h0);
    check("rr_stall_wait", 32'(stall), 32'h1);
    rstn = 1'b0;
    #1;
    check("rr_stall_rst", 32'(stall), 32'h0);
    check("rr_req_rst", 32'(bus.req), 32'h0);
    check("rr_wb_rst", 32'(wb.valid), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h5555_5555;
    #1;
    check("rr_stall_late", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("rr_wb_late", 32'(wb.valid), 32'h0);

    // Misaligned word access
    @(negedge clk);
    idle();
    put(MEM_LOAD, WORD, 1'b0, 32'h102, 32'h0);
    bus.gnt = 1'b1; bus.rvalid = 1'b1;
    bus.rdata = 32'h0BAD_F00D;
    #1;
    check("mis_stall", 32'(stall), 32'h0);
`ifdef MEM_MISALIGN_EXC_EN
    check("mis_req", 32'(bus.req), 32'h0);
    @(posedge clk); #1;
    check("mis_wb_valid", 32'(wb.valid), 32'h1);
    check("mis_exc", 32'(wb.exc_misaligned), 32'h1);
    check("mis_result", wb.result, 32'h102);
`else
    check("mis_req", 32'(bus.req), 32'h1);
    check("mis_addr", bus.addr, 32'h100);
    check("mis_be", 32'(bus.be), 32'hF);
    @(posedge clk); #1;
    check("mis_wb_valid", 32'(wb.valid), 32'h1);
    check("mis_exc", 32'(wb.exc_misaligned), 32'h0);
    check("mis_result", wb.result, 32'h0BAD_F00D);
`endif

    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check("end_wb_valid", 32'(wb.valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
